// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// State encodings are fixed because state_o exposes them for debug.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    QUALIFY   = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  // Defaults derived from the 27 MHz crystal clock
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 64;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 270000;  // 10 ms
  localparam int DEF_LOCK_STABLE_CYCLES  = 2700;    // 100 us
  localparam int DEF_CNT_W               = 20;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Saturating increment used by the lock-loss counter
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] value);
    return (value == LOSS_CNT_MAX) ? value : value + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// sync_ff: N-stage single-bit synchronizer with synchronous reset to 0.
// STAGES must be at least 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the rPLL reset, qualifies its lock output
// and holds downstream logic in reset until the PLL clock is stable.
// Optional feature macro: PLL_SUP_LOSS_COUNT_EN builds the saturating
// lock-loss counter; without it loss_count is tied to zero.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  lock,
  input  logic                  force_relock,
  output logic                  pll_reset,
  output logic                  sys_rst,
  output logic                  locked_stable,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            state_o
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  pll_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clkin),
    .reset(reset),
    .d    (lock),
    .q    (lock_s)
  );

  // Sequencing FSM with a shared cycle counter that restarts on every state change;
  // force_relock beats a lock drop, which beats the counter terminal condition
  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= RESET_PLL;
      cnt   <= '0;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (force_relock) begin
            state <= RESET_PLL;
            cnt   <= '0;
          end else if (lock_s) begin
            state <= QUALIFY;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state <= RESET_PLL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        QUALIFY: begin
          if (force_relock) begin
            state <= RESET_PLL;
            cnt   <= '0;
          end else if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (force_relock || !lock_s) begin
            state <= RESET_PLL;
            cnt   <= '0;
          end
        end
        default: begin
          state <= RESET_PLL;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic                  loss_event;
  logic [LOSS_CNT_W-1:0] loss_q;

  // A forced relock is deliberate, so only a genuine lock drop in RUN counts
  assign loss_event = (state == RUN) && !force_relock && !lock_s;

  // Saturating lock-loss counter for debug
  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_q <= '0;
    end else if (loss_event) begin
      loss_q <= sat_inc(loss_q);
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

  assign pll_reset     = (state == RESET_PLL);
  assign sys_rst       = (state != RUN);
  assign locked_stable = (state == RUN);
  assign state_o       = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: a table of directed vectors
// plus hand-written sequences for reset-in-RUN and loss-counter saturation.
module tb_pll_lock_supervisor;

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_QUAL = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

`ifdef PLL_SUP_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       lock = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked_stable;
  logic [7:0] loss_count;
  logic [1:0] state_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         n;
    logic       rst;
    logic       lk;
    logic       frc;
    logic [1:0] st;
    int         loss;
  } vec_t;

  vec_t vecs[$];

  pll_lock_supervisor #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8),
    .CNT_W(20)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .lock         (lock),
    .force_relock (force_relock),
    .pll_reset    (pll_reset),
    .sys_rst      (sys_rst),
    .locked_stable(locked_stable),
    .loss_count   (loss_count),
    .state_o      (state_o)
  );

  always #5 clkin = ~clkin;

  // Watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_vec(input int n, input logic rst, input logic lk, input logic frc,
                         input logic [1:0] st, input int loss);
    vec_t v;
    v.n = n; v.rst = rst; v.lk = lk; v.frc = frc; v.st = st; v.loss = loss;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one edge, settle 1 time unit past the edge
  task automatic apply_stimulus(input logic rst, input logic lk, input logic frc);
    reset = rst;
    lock = lk;
    force_relock = frc;
    @(posedge clkin);
    #1;
  endtask

  task automatic compare(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input logic [1:0] st, input int loss);
    int exp_loss;
    exp_loss = LOSS_EN ? ((loss > 255) ? 255 : loss) : 0;
    compare({name, ".state"},         int'(state_o),       int'(st));
    compare({name, ".pll_reset"},     int'(pll_reset),     (st == S_RST) ? 1 : 0);
    compare({name, ".sys_rst"},       int'(sys_rst),       (st != S_RUN) ? 1 : 0);
    compare({name, ".locked_stable"}, int'(locked_stable), (st == S_RUN) ? 1 : 0);
    compare({name, ".loss_count"},    int'(loss_count),    exp_loss);
  endtask

  // Step with fixed inputs until the target state appears, within a cycle budget
  task automatic wait_state(input string name, input logic [1:0] st, input logic lk,
                            input int limit);
    int k;
    k = 0;
    while (state_o != st && k < limit) begin
      apply_stimulus(1'b0, lk, 1'b0);
      k++;
    end
    total++;
    if (state_o != st) begin
      bad++;
      $display("[TB] FAIL %s: state %0d after %0d cycles, expected %0d", name, state_o, k, st);
    end
  endtask

  task automatic lose_once(input string name);
    wait_state({name, ".to_run"}, S_RUN, 1'b1, 100);
    wait_state({name, ".to_rst"}, S_RST, 1'b0, 10);
  endtask

  initial begin
    // Cold start: timeout retry loop with lock held low
    add_vec(3,  1'b1, 1'b0, 1'b0, S_RST,  0);
    add_vec(3,  1'b0, 1'b0, 1'b0, S_RST,  0);
    add_vec(32, 1'b0, 1'b0, 1'b0, S_WAIT, 0);
    add_vec(4,  1'b0, 1'b0, 1'b0, S_RST,  0);
    add_vec(5,  1'b0, 1'b0, 1'b0, S_WAIT, 0);
    // Normal lock: lock first sampled at edge 11, QUALIFY at 13, RUN at 21
    add_vec(1,  1'b1, 1'b0, 1'b0, S_RST,  0);
    add_vec(3,  1'b0, 1'b0, 1'b0, S_RST,  0);
    add_vec(7,  1'b0, 1'b0, 1'b0, S_WAIT, 0);
    add_vec(2,  1'b0, 1'b1, 1'b0, S_WAIT, 0);
    add_vec(8,  1'b0, 1'b1, 1'b0, S_QUAL, 0);
    add_vec(3,  1'b0, 1'b1, 1'b0, S_RUN,  0);
    // Lock loss in RUN: two more RUN edges, then RESET_PLL on the third
    add_vec(2,  1'b0, 1'b0, 1'b0, S_RUN,  0);
    add_vec(1,  1'b0, 1'b0, 1'b0, S_RST,  1);
    // force_relock during RESET_PLL is ignored
    add_vec(3,  1'b0, 1'b0, 1'b1, S_RST,  1);
    add_vec(1,  1'b0, 1'b0, 1'b1, S_WAIT, 1);
    // force_relock in WAIT_LOCK
    add_vec(1,  1'b0, 1'b0, 1'b1, S_RST,  1);
    // Relock, then force together with a lock_s drop in RUN
    add_vec(3,  1'b0, 1'b1, 1'b0, S_RST,  1);
    add_vec(1,  1'b0, 1'b1, 1'b0, S_WAIT, 1);
    add_vec(8,  1'b0, 1'b1, 1'b0, S_QUAL, 1);
    add_vec(1,  1'b0, 1'b1, 1'b0, S_RUN,  1);
    add_vec(2,  1'b0, 1'b0, 1'b0, S_RUN,  1);
    add_vec(1,  1'b0, 1'b0, 1'b1, S_RST,  1);
    // Single-cycle glitch in QUALIFY restarts qualification
    add_vec(1,  1'b1, 1'b0, 1'b0, S_RST,  0);
    add_vec(3,  1'b0, 1'b0, 1'b0, S_RST,  0);
    add_vec(2,  1'b0, 1'b1, 1'b0, S_WAIT, 0);
    add_vec(2,  1'b0, 1'b1, 1'b0, S_QUAL, 0);
    add_vec(1,  1'b0, 1'b0, 1'b0, S_QUAL, 0);
    add_vec(1,  1'b0, 1'b1, 1'b0, S_QUAL, 0);
    add_vec(1,  1'b0, 1'b1, 1'b0, S_WAIT, 0);
    add_vec(8,  1'b0, 1'b1, 1'b0, S_QUAL, 0);
    add_vec(2,  1'b0, 1'b1, 1'b0, S_RUN,  0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        apply_stimulus(vecs[i].rst, vecs[i].lk, vecs[i].frc);
        check_output($sformatf("vec%0d.c%0d", i, c), vecs[i].st, vecs[i].loss);
      end
    end

    // Reset asserted in RUN after five losses
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("rst5.init", S_RST, 0);
    for (int n = 1; n <= 5; n++) begin
      lose_once($sformatf("rst5.loss%0d", n));
    end
    wait_state("rst5.run", S_RUN, 1'b1, 100);
    check_output("rst5.in_run", S_RUN, 5);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("rst5.after_reset", S_RST, 0);

    // Saturation of the loss counter
    apply_stimulus(1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 300; n++) begin
      lose_once($sformatf("sat.loss%0d", n));
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
        check_output($sformatf("sat.n%0d", n), S_RST, n);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

PLL bring-up and lock supervisor. Runs on the free-running 27 MHz crystal clock and drives the rPLL `RESET` input. It qualifies the asynchronous PLL `lock` output and holds the cartridge logic in reset until the 108 MHz clock is stable. It also re-sequences the PLL on lock loss or lock timeout, and counts lock-loss events for debug.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `lock` synchronizer; legal range 2–4.
- `PLL_RST_CYCLES`, 64: cycles `pll_reset` is held high per sequence; ≥1.
- `LOCK_TIMEOUT_CYCLES`, 270000: maximum wait for lock (10 ms at 27 MHz); ≥1.
- `LOCK_STABLE_CYCLES`, 2700: consecutive synchronized-lock cycles required before release (100 µs); ≥1.
- `CNT_W`, 20: width of the shared cycle counter. It must hold max(all three cycle parameters).

Ports:
- `clkin` in 1: 27 MHz crystal clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `lock` in 1: rPLL LOCK; asynchronous to `clkin`.
- `force_relock` in 1: single-cycle request to restart the PLL sequence.
- `pll_reset` out 1: to rPLL `RESET`; high = PLL held in reset.
- `sys_rst` out 1: high = downstream logic held in reset. It is synchronized into the 108 MHz domain externally.
- `locked_stable` out 1: high only in RUN.
- `loss_count` out 8: saturating count of lock losses while in RUN.
- `state_o` out 2: current state encoding, for debug.

## Operation
- `lock` passes through a `SYNC_STAGES`-deep flop chain, giving `lock_s`. All decisions use `lock_s`.
- States:
  - RESET_PLL=0: `pll_reset`=1.
  - WAIT_LOCK=1.
  - QUALIFY=2.
  - RUN=3.
- One `CNT_W` counter `cnt` is cleared on every state change.
- RESET_PLL:
  - `cnt` increments each cycle.
  - When `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`=1, go to QUALIFY.
  - Otherwise, when `cnt == LOCK_TIMEOUT_CYCLES-1`, go to RESET_PLL (retry indefinitely).
- QUALIFY:
  - If `lock_s`=0, go to WAIT_LOCK. The timeout window restarts.
  - Otherwise, when `cnt == LOCK_STABLE_CYCLES-1`, go to RUN.
- RUN:
  - If `lock_s`=0, go to RESET_PLL and increment `loss_count`. It saturates at 255; no wrap.
- `force_relock`=1 in WAIT_LOCK, QUALIFY or RUN sends the block to RESET_PLL on the next edge. It does not increment `loss_count`, and it takes priority over a simultaneous `lock_s` drop.
- `force_relock` in RESET_PLL is ignored; the sequence is not restarted.
- Output decode:
  - `pll_reset` = (state==RESET_PLL).
  - `sys_rst` = (state!=RUN).
  - `locked_stable` = (state==RUN).
  - All three decode from the state register only; no input-to-output combinational path.

## Timing
- During `reset`:
  - state=RESET_PLL, `cnt`=0, synchronizer flops=0, `loss_count`=0.
  - Outputs: `pll_reset`=1, `sys_rst`=1, `locked_stable`=0, `state_o`=0.
- Reset mid-operation, from any state, returns everything to these values on the next edge. `loss_count` is cleared.
- After `reset` falls, `pll_reset` stays high for exactly `PLL_RST_CYCLES` cycles.
- A `lock` rise reaches `lock_s` after `SYNC_STAGES` edges.
- QUALIFY is entered one edge after `lock_s` rises. RUN is entered `LOCK_STABLE_CYCLES` edges after that.
- A `lock` fall in RUN produces `sys_rst`=1 and `pll_reset`=1 `SYNC_STAGES`+1 edges after the fall.
- A `lock_s` glitch of 1 cycle in QUALIFY restarts qualification; RUN is never entered early.
- Timeout, qualify-complete and force are evaluated on the same edge. Priority: `force_relock` > `lock_s` drop > counter terminal condition.

## Configuration
- `PLL_SUP_LOSS_COUNT_EN` defined: the 8-bit saturating loss counter is implemented as described.
- Macro not defined: the counter is not built and `loss_count` is tied to 8'h00. All other behaviour is identical.

## Structure
- Package `pll_sup_pkg` holds:
  - the 2-bit state typedef and its encodings;
  - default parameter constants (27 MHz derived cycle counts);
  - `LOSS_CNT_W`=8.
- Sub-module `sync_ff` is a parameterized N-stage single-bit synchronizer with synchronous reset to 0. It is instantiated once for `lock`.
- Everything else (FSM, counter, loss counter) lives in the top module.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8.
- Cold start: `reset` for 3 cycles, `lock` held 0 → `pll_reset` high for 4 cycles after release, then 32 cycles in WAIT_LOCK, then `pll_reset` high again (retry loop repeats).
- Normal lock: `lock` rises at cycle 10 after release → QUALIFY at cycle 13, RUN at cycle 21. `sys_rst`=0 and `locked_stable`=1 from cycle 21.
- Qualify glitch: `lock` low for 1 cycle during QUALIFY → return to WAIT_LOCK, then a full 8-cycle requalification. `sys_rst` never drops early.
- Loss in RUN: `lock` falls → `sys_rst`=1 exactly 3 edges later, `loss_count`=1. With the macro defined, 300 losses give `loss_count`=255. With the macro undefined, `loss_count`=0.
- Force relock in RUN with a simultaneous `lock` drop → RESET_PLL next edge, `loss_count` unchanged.
- `reset` asserted in RUN after 5 losses → all outputs return to reset values and `loss_count`=0 on the next edge.
